// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - register-file port and dump stream bundle for regfile_sequencer
interface regfile_sequencer_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_W      = 5
);
  logic                   RegWrite;
  logic [ADDR_W-1:0]      WriteRegister;
  logic [WORD_LENGTH-1:0] WriteData;
  logic [ADDR_W-1:0]      ReadRegister1;
  logic [ADDR_W-1:0]      ReadRegister2;
  logic [WORD_LENGTH-1:0] ReadData1;
  logic [WORD_LENGTH-1:0] ReadData2;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [ADDR_W-1:0]      dump_addr;
  logic [WORD_LENGTH-1:0] dump_data;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2,
    output dump_valid, dump_addr, dump_data,
    input  dump_ready
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2,
    input  dump_valid, dump_addr, dump_data,
    output dump_ready
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - walks a register file, loading an arithmetic pattern or dumping it as a stream
module regfile_sequencer #(
  parameter int WORD_LENGTH = 32,
  parameter int N           = 32,
  parameter int ADDR_W      = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [WORD_LENGTH-1:0] seed,
  input  logic [WORD_LENGTH-1:0] step,
  output logic                   busy,
  output logic                   done,
  regfile_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    EMIT0,
    EMIT1,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(N - 2);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  state_t                 state;
  state_t                 state_n;
  logic [ADDR_W-1:0]      idx;
  logic [ADDR_W-1:0]      idx_p1;
  logic [WORD_LENGTH-1:0] acc;
  logic [WORD_LENGTH-1:0] step_q;
  logic [WORD_LENGTH-1:0] buf0;
  logic [WORD_LENGTH-1:0] buf1;
  // Last driven indices/data, so the register-file port holds outside its active state
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [WORD_LENGTH-1:0] wr_data_q;
  logic [ADDR_W-1:0]      rd_addr1_q;
  logic [ADDR_W-1:0]      rd_addr2_q;

  assign idx_p1 = idx + ONE;

  // State register; reset aborts any command and parks in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and all outputs, driven straight from state and datapath registers
  always_comb begin
    state_n           = state;
    busy              = (state != IDLE);
    done              = (state == DONE);
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = wr_addr_q;
    bus.WriteData     = wr_data_q;
    bus.ReadRegister1 = rd_addr1_q;
    bus.ReadRegister2 = rd_addr2_q;
    bus.dump_valid    = 1'b0;
    bus.dump_addr     = '0;
    bus.dump_data     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = mode ? READ : LOAD;
        end
      end
      LOAD: begin
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = idx;
        bus.WriteData     = acc;
        if (idx == LAST_IDX) begin
          state_n = DONE;
        end
      end
      READ: begin
        bus.ReadRegister1 = idx;
        bus.ReadRegister2 = idx_p1;
        state_n           = EMIT0;
      end
      EMIT0: begin
        bus.dump_valid = 1'b1;
        bus.dump_addr  = idx;
        bus.dump_data  = buf0;
        if (bus.dump_ready) begin
          state_n = EMIT1;
        end
      end
      EMIT1: begin
        bus.dump_valid = 1'b1;
        bus.dump_addr  = idx_p1;
        bus.dump_data  = buf1;
        if (bus.dump_ready) begin
          state_n = (idx == LAST_PAIR) ? DONE : READ;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath: index walk, pattern accumulator, read capture and held port values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      acc        <= '0;
      step_q     <= '0;
      buf0       <= '0;
      buf1       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            acc    <= seed;
            step_q <= step;
          end
        end
        LOAD: begin
          wr_addr_q <= idx;
          wr_data_q <= acc;
          idx       <= idx_p1;
          acc       <= acc + step_q;
        end
        READ: begin
          rd_addr1_q <= idx;
          rd_addr2_q <= idx_p1;
          buf0       <= bus.ReadData1;
          buf1       <= bus.ReadData2;
        end
        EMIT1: begin
          if (bus.dump_ready && (idx != LAST_PAIR)) begin
            idx <= idx + TWO;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer with a behavioural register-file model
module tb_regfile_sequencer;
  localparam int WL = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  typedef struct {
    bit          beat;
    int          addr;
    logic [WL-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [WL-1:0] seed;
  logic [WL-1:0] step;
  logic          busy;
  logic          done;

  regfile_sequencer_if #(.WORD_LENGTH(WL), .ADDR_W(AW)) bus ();

  regfile_sequencer #(.WORD_LENGTH(WL), .N(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .seed  (seed),
    .step  (step),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [WL-1:0] rf      [N];
  logic [WL-1:0] ref_mem [N];
  exp_t          expq[$];
  exp_t          mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  int            ready_policy = 0;

  // Register file seen by the sequencer: synchronous write, combinational read
  always @(posedge clk) begin
    if (bus.RegWrite) rf[bus.WriteRegister] <= bus.WriteData;
  end
  assign bus.ReadData1 = rf[bus.ReadRegister1];
  assign bus.ReadData2 = rf[bus.ReadRegister2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink backpressure: 0 always ready, 1 random, 2 held low
  initial begin
    bus.dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_policy)
        0: bus.dump_ready = 1'b1;
        1: bus.dump_ready = 1'($urandom_range(0, 1));
        default: bus.dump_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every write and every accepted beat must match the next expected event
  always @(negedge clk) begin
    if (reset) begin
      if (bus.RegWrite) begin
        if (expq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_e = expq.pop_front();
          check("write_kind", 0, 64'(mon_e.beat));
          check("write_addr", 64'(bus.WriteRegister), 64'(mon_e.addr));
          check("write_data", 64'(bus.WriteData), 64'(mon_e.data));
        end
      end
      if (bus.dump_valid && bus.dump_ready) begin
        if (expq.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          mon_e = expq.pop_front();
          check("beat_kind", 1, 64'(mon_e.beat));
          check("beat_addr", 64'(bus.dump_addr), 64'(mon_e.addr));
          check("beat_data", 64'(bus.dump_data), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_regwrite"}, 64'(bus.RegWrite), 0);
    check({tag, "_dump_valid"}, 64'(bus.dump_valid), 0);
    check({tag, "_wr_addr"}, 64'(bus.WriteRegister), 0);
    check({tag, "_wr_data"}, 64'(bus.WriteData), 0);
    check({tag, "_rd_addr1"}, 64'(bus.ReadRegister1), 0);
    check({tag, "_rd_addr2"}, 64'(bus.ReadRegister2), 0);
    check({tag, "_dump_addr"}, 64'(bus.dump_addr), 0);
    check({tag, "_dump_data"}, 64'(bus.dump_data), 0);
  endtask

  // Issue one command; LOAD expects register k = s + k*st for the first lim registers
  task automatic issue(input bit m, input logic [WL-1:0] s, input logic [WL-1:0] st, input int lim);
    exp_t e;
    @(posedge clk);
    #1;
    if (!m) begin
      for (int k = 0; k < lim; k++) begin
        ref_mem[k] = s + st * WL'(k);
        e.beat = 1'b0; e.addr = k; e.data = ref_mem[k];
        expq.push_back(e);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        e.beat = 1'b1; e.addr = k; e.data = ref_mem[k];
        expq.push_back(e);
      end
    end
    start = 1'b1;
    mode  = m;
    seed  = s;
    step  = st;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = $urandom;
    step  = $urandom;
  endtask

  // Wait for done; exp_c > 0 demands done in cycle start_edge + exp_c
  task automatic wait_done(input int exp_c, input bit noise);
    int c = 0;
    bit seen = 1'b0;
    while (c < 400 && !seen) begin
      @(negedge clk);
      c++;
      if (c == 1) check("busy_after_start", 64'(busy), 1);
      if (done) seen = 1'b1;
      if (noise) begin
        start = done || (bus.RegWrite && (bus.WriteRegister == 5'd10 || bus.WriteRegister == 5'd11));
        mode  = 1'($urandom_range(0, 1));
        seed  = $urandom;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    else if (exp_c > 0) check("done_latency", 64'(c), 64'(exp_c));
    check("queue_drained", 64'(expq.size()), 0);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    seed  = '0;
    step  = '0;
    #12;
    check_cleared("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ramp load 3 + 4k, then full-speed dump
    issue(1'b0, 32'd3, 32'd4, N);
    wait_done(N + 1, 1'b0);
    check("wr_addr_hold", 64'(bus.WriteRegister), 31);
    check("wr_data_hold", 64'(bus.WriteData), 127);
    check("reg31", 64'(rf[31]), 127);
    ready_policy = 0;
    issue(1'b1, '0, '0, 0);
    wait_done(3 * N / 2 + 1, 1'b0);

    // Stall the addr=2 beat for five cycles
    issue(1'b1, '0, '0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.dump_valid && bus.dump_ready && bus.dump_addr == 5'd1) found = 1'b1;
    end
    check("stall_reached", 64'(found), 1);
    ready_policy = 2;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.dump_valid), 1);
      check("stall_addr", 64'(bus.dump_addr), 2);
      check("stall_data", 64'(bus.dump_data), 11);
      if (i == 4) ready_policy = 0;
      @(posedge clk);
    end
    wait_done(0, 1'b0);

    // Accumulator wrap
    issue(1'b0, 32'hFFFF_FFF0, 32'd1, N);
    wait_done(N + 1, 1'b0);
    check("wrap_reg15", 64'(rf[15]), 64'h0000_0000_FFFF_FFFF);
    check("wrap_reg16", 64'(rf[16]), 0);
    check("wrap_reg31", 64'(rf[31]), 15);

    // Start pulses mid-LOAD and in the DONE cycle are ignored
    issue(1'b0, $urandom, $urandom, N);
    wait_done(N + 1, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_done_start", 64'(busy), 0);

    // Reset while register 7 is being written
    issue(1'b0, $urandom, $urandom, 7);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.RegWrite && bus.WriteRegister == 5'd6) found = 1'b1;
    end
    check("abort_reached", 64'(found), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_cleared("abort");
    check("abort_queue", 64'(expq.size()), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_abort", 64'(busy), 0);
    ready_policy = 1;
    issue(1'b1, '0, '0, 0);
    wait_done(0, 1'b0);

    // Random patterns under random and full-rate backpressure
    for (int r = 0; r < 4; r++) begin
      ready_policy = r % 2;
      issue(1'b0, $urandom, $urandom, N);
      wait_done(N + 1, 1'b0);
      issue(1'b1, '0, '0, 0);
      wait_done((r % 2 == 0) ? (3 * N / 2 + 1) : 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter WORD_LENGTH, default 32, data width of every word, seed and step.
REQ-002 Parameter N, default 32, number of registers walked; SHALL be even and equal 2^ADDR_W.
REQ-003 Parameter ADDR_W, default 5, register index width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  command strobe, sampled only in IDLE.
REQ-007 mode  input  1  sampled with start: 0 = LOAD, 1 = DUMP.
REQ-008 seed, step  input  WORD_LENGTH each  LOAD pattern base and increment, sampled with start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse at the end of a command.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 WriteRegister  output  ADDR_W  write index.
REQ-013 WriteData  output  WORD_LENGTH  write data.
REQ-014 ReadRegister1, ReadRegister2  output  ADDR_W each  read indices.
REQ-015 ReadData1, ReadData2  input  WORD_LENGTH each  combinational read data from the register file.
REQ-016 dump_valid  output  1, dump_ready  input  1  streaming handshake for DUMP output.
REQ-017 dump_addr  output  ADDR_W, dump_data  output  WORD_LENGTH  index and contents of the current beat.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, READ, EMIT0, EMIT1 and DONE, with a single index register idx.
REQ-019 IDLE with start=1 SHALL clear idx to 0, latch seed into the data accumulator, latch step, and go to LOAD (mode=0) or READ (mode=1).
REQ-020 LOAD SHALL drive RegWrite=1, WriteRegister=idx and WriteData=accumulator every cycle, then advance idx by 1 and the accumulator by step (modulo 2^WORD_LENGTH).
REQ-021 LOAD SHALL go to DONE after the write of idx=N-1, for exactly N write cycles.
REQ-022 READ SHALL drive ReadRegister1=idx and ReadRegister2=idx+1, capture ReadData1/ReadData2 into buf0/buf1 at the clock edge, and go to EMIT0.
REQ-023 EMIT0 SHALL drive dump_valid=1, dump_addr=idx and dump_data=buf0, and go to EMIT1 on dump_valid&dump_ready.
REQ-024 EMIT1 SHALL drive dump_valid=1, dump_addr=idx+1 and dump_data=buf1; on handshake it SHALL go to DONE if idx+1=N-1, otherwise advance idx by 2 and return to READ.
REQ-025 While dump_valid=1 and dump_ready=0, dump_addr and dump_data SHALL hold stable.
REQ-026 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-027 RegWrite SHALL be 0 in every state except LOAD; a DUMP SHALL never write the register file.
REQ-028 start in any state other than IDLE SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-029 Outside READ, ReadRegister1/2 SHALL hold their last value; outside LOAD, WriteRegister/WriteData SHALL hold their last value.
REQ-030 Latency, start sampled at edge t, LOAD: first write in the cycle after t, done asserted in cycle t+N+1.
REQ-031 Latency, start sampled at edge t, DUMP with dump_ready held high: 3 cycles per pair, done asserted in cycle t+3N/2+1.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE and clear idx, accumulator, step, buf0 and buf1 to 0.
REQ-033 reset=0 SHALL immediately drive busy, done, RegWrite and dump_valid to 0, and all address and data outputs to 0.
REQ-034 Reset asserted mid-command SHALL abort the command with no further register-file write; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-035 LOAD with seed=3, step=4 -> register k written with 3+4k (reg31=127); RegWrite high for exactly 32 cycles; done 33 cycles after the start edge.
REQ-036 DUMP after REQ-035 with dump_ready=1 -> 32 beats, addr 0..31, data 3,7,11,...,127; done 49 cycles after start; RegWrite stays 0.
REQ-037 DUMP with dump_ready held 0 for 5 cycles at the addr=2 beat -> dump_valid=1 with addr 2 and data 11 held for all 5 cycles; no beat lost or repeated.
REQ-038 LOAD with seed=32'hFFFF_FFF0, step=1 -> reg15=32'hFFFF_FFFF, reg16=0 (wrap), reg31=15.
REQ-039 start pulses during a LOAD at idx=10 -> ignored; sequence and done timing unchanged.
REQ-040 reset=0 at idx=7 of a LOAD -> outputs cleared immediately, registers 7..31 not written, busy=0 until the next start.
